// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl
//   Control FSM for a SHA-256 compression datapath. Accepts 512-bit message
//   blocks via a valid/ready handshake, sequences the working-variable load,
//   ROUNDS compression rounds, the digest update and multi-block chaining,
//   and drives the round index into the K_t constant ROM.
//
// Ports
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   blk_valid/ready     : block handshake (blk_first/blk_last qualify valid)
//   round_cnt           : round index to the K_t ROM (0 outside ROUND)
//   ld_msg/ld_init/ld_chain, rnd_en, w_sel, digest_upd : datapath strobes
//   digest_valid/ready  : digest handshake
//   busy                : controller not idle
//   seq_err             : one-cycle pulse on a first/chain mismatch
//   blk_cnt             : blocks compressed in the current message
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The source holds its data (and valid) until that edge; valid while
// ready is low has no effect.
module sha256_round_ctrl #(
  parameter int ROUNDS = 64,
  parameter int BCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blk_valid,
  input  logic              blk_first,
  input  logic              blk_last,
  output logic              blk_ready,
  output logic [5:0]        round_cnt,
  output logic              ld_msg,
  output logic              ld_init,
  output logic              ld_chain,
  output logic              rnd_en,
  output logic              w_sel,
  output logic              digest_upd,
  output logic              digest_valid,
  input  logic              digest_ready,
  output logic              busy,
  output logic              seq_err,
  output logic [BCNT_W-1:0] blk_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ROUND  = 3'd2,
    S_UPDATE = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

  state_t state;
  state_t state_nxt;

  logic first_r;     // block is loaded from H0..H7 rather than chained
  logic last_r;      // block closes the message
  logic err_r;       // first flag disagreed with the chain state at accept
  logic chain_open;  // a message is in progress between blocks
  logic accept;

  assign accept = blk_valid & blk_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_ROUND;
      S_ROUND:  if (round_cnt == LAST_RND) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = last_r ? S_OUT : S_IDLE;
      S_OUT:    if (digest_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Block flags, round counter, block counter and chain state
  always_ff @(posedge clk) begin
    if (rst) begin
      first_r    <= 1'b0;
      last_r     <= 1'b0;
      err_r      <= 1'b0;
      chain_open <= 1'b0;
      round_cnt  <= 6'd0;
      blk_cnt    <= '0;
    end else begin
      if (accept) begin
        // With no open chain, every block is treated as a first block.
        first_r <= blk_first | ~chain_open;
        last_r  <= blk_last;
        // Error when first=0 with no chain, or first=1 over an open chain.
        err_r   <= (blk_first == chain_open);
      end
      case (state)
        S_LOAD: begin
          round_cnt <= 6'd0;
          if (first_r) blk_cnt <= '0;
        end
        S_ROUND: begin
          if (round_cnt == LAST_RND) round_cnt <= 6'd0;
          else                       round_cnt <= round_cnt + 6'd1;
        end
        S_UPDATE: begin
          round_cnt  <= 6'd0;
          blk_cnt    <= blk_cnt + BCNT_W'(1);
          chain_open <= ~last_r;
        end
        default: round_cnt <= 6'd0;
      endcase
    end
  end

  // Output logic
  always_comb begin
    blk_ready    = 1'b0;
    ld_msg       = 1'b0;
    ld_init      = 1'b0;
    ld_chain     = 1'b0;
    rnd_en       = 1'b0;
    w_sel        = 1'b0;
    digest_upd   = 1'b0;
    digest_valid = 1'b0;
    seq_err      = 1'b0;
    busy         = 1'b1;
    case (state)
      S_IDLE: begin
        blk_ready = 1'b1;
        busy      = 1'b0;
      end
      S_LOAD: begin
        ld_msg   = 1'b1;
        ld_init  = first_r;
        ld_chain = ~first_r;
        seq_err  = err_r;
      end
      S_ROUND: begin
        rnd_en = 1'b1;
        // Rounds 0..15 use the block words directly; later rounds use the
        // schedule recurrence.
        w_sel  = (round_cnt >= 6'd16);
      end
      S_UPDATE: digest_upd   = 1'b1;
      S_OUT:    digest_valid = 1'b1;
      default:  busy         = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
module tb_sha256_round_ctrl;
  localparam int W  = 16;
  localparam int R  = 64;
  localparam int R4 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Full-length instance
  logic        blk_valid, blk_first, blk_last, digest_ready;
  logic        blk_ready, ld_msg, ld_init, ld_chain, rnd_en, w_sel;
  logic        digest_upd, digest_valid, busy, seq_err;
  logic [5:0]  round_cnt;
  logic [15:0] blk_cnt;

  // Short-round instance
  logic        blk_valid_4, blk_first_4, blk_last_4, digest_ready_4;
  logic        blk_ready_4, ld_msg_4, ld_init_4, ld_chain_4, rnd_en_4, w_sel_4;
  logic        digest_upd_4, digest_valid_4, busy_4, seq_err_4;
  logic [5:0]  round_cnt_4;
  logic [15:0] blk_cnt_4;

  sha256_round_ctrl #(.ROUNDS(R), .BCNT_W(16)) dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_first(blk_first),
    .blk_last(blk_last), .blk_ready(blk_ready), .round_cnt(round_cnt),
    .ld_msg(ld_msg), .ld_init(ld_init), .ld_chain(ld_chain), .rnd_en(rnd_en),
    .w_sel(w_sel), .digest_upd(digest_upd), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .busy(busy), .seq_err(seq_err),
    .blk_cnt(blk_cnt)
  );

  sha256_round_ctrl #(.ROUNDS(R4), .BCNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .blk_valid(blk_valid_4), .blk_first(blk_first_4),
    .blk_last(blk_last_4), .blk_ready(blk_ready_4), .round_cnt(round_cnt_4),
    .ld_msg(ld_msg_4), .ld_init(ld_init_4), .ld_chain(ld_chain_4),
    .rnd_en(rnd_en_4), .w_sel(w_sel_4), .digest_upd(digest_upd_4),
    .digest_valid(digest_valid_4), .digest_ready(digest_ready_4),
    .busy(busy_4), .seq_err(seq_err_4), .blk_cnt(blk_cnt_4)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic         model_chain;
  logic [15:0]  model_cnt;

  // Observed vector of the full-length instance
  function automatic logic [W-1:0] obs();
    return {ld_msg, ld_init, ld_chain, rnd_en, w_sel, digest_upd, seq_err,
            busy, blk_ready, digest_valid, round_cnt};
  endfunction

  function automatic logic [W-1:0] mk(input logic lm, li, lc, re, ws, du, se,
                                      bu, br, dv, input logic [5:0] rc);
    return {lm, li, lc, re, ws, du, se, bu, br, dv, rc};
  endfunction

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one block on the full-length instance and check every cycle from
  // LOAD through UPDATE against the queued expectation.
  task automatic run_block(input logic first, input logic last);
    logic         fe, err;
    logic [W-1:0] e;
    n_checks++;
    if (blk_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL blk_ready_before_accept: got %b want 1", blk_ready);
    end
    fe  = first | ~model_chain;
    err = (first == model_chain);
    exp_q.push_back(mk(1, fe, ~fe, 0, 0, 0, err, 1, 0, 0, 6'd0));
    for (int r = 0; r < R; r++)
      exp_q.push_back(mk(0, 0, 0, 1, (r >= 16), 0, 0, 1, 0, 0, 6'(r)));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 6'd0));
    if (fe) model_cnt = 16'd0;
    model_cnt   = model_cnt + 16'd1;
    model_chain = ~last;

    blk_valid = 1'b1; blk_first = first; blk_last = last;
    step();
    blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
    for (int i = 0; i < R + 2; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL block_cycle_%0d: got %h want %h", i, obs(), e);
      end
      step();
    end
    n_checks++;
    if (blk_cnt !== model_cnt) begin
      n_fail++;
      $display("FAIL blk_cnt_after_update: got %0d want %0d", blk_cnt, model_cnt);
    end
    n_checks++;
    if (digest_valid !== last || blk_ready !== ~last) begin
      n_fail++;
      $display("FAIL post_update_state: got dv=%b rdy=%b want dv=%b rdy=%b",
               digest_valid, blk_ready, last, ~last);
    end
  endtask

  task automatic drain_out();
    digest_ready = 1'b1;
    step();
    digest_ready = 1'b0;
    n_checks++;
    if (digest_valid !== 1'b0 || blk_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_to_idle: got dv=%b rdy=%b busy=%b want 0 1 0",
               digest_valid, blk_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    model_chain = 1'b0; model_cnt = 16'd0;
    n_checks++;
    if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'd0) || blk_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h cnt=%0d want %h cnt=0", obs(), blk_cnt,
               mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'd0));
    end
    n_checks++;
    if (blk_ready_4 !== 1'b1 || busy_4 !== 1'b0 || round_cnt_4 !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_state_r4: got rdy=%b busy=%b rc=%0d want 1 0 0",
               blk_ready_4, busy_4, round_cnt_4);
    end
    step();
  endtask

  task automatic test_single_block();
    run_block(1'b1, 1'b1);
    drain_out();
  endtask

  // Two-block message followed by a consumer stall in OUT; a block offered
  // during the stall must be ignored.
  task automatic test_two_block_stall();
    run_block(1'b1, 1'b0);
    run_block(1'b0, 1'b1);
    blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (digest_valid !== 1'b1 || blk_ready !== 1'b0 || blk_cnt !== 16'd2) begin
        n_fail++;
        $display("FAIL out_stall_%0d: got dv=%b rdy=%b cnt=%0d want 1 0 2",
                 i, digest_valid, blk_ready, blk_cnt);
      end
    end
    blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
    drain_out();
  endtask

  task automatic test_seq_err();
    run_block(1'b0, 1'b1);   // no open chain, first=0
    drain_out();
    run_block(1'b1, 1'b0);
    run_block(1'b1, 1'b1);   // first=1 over an open chain
    drain_out();
  endtask

  task automatic test_reset_mid_round();
    bit hit = 0;
    blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b0;
    step();
    blk_valid = 1'b0; blk_first = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (rnd_en === 1'b1 && round_cnt === 6'd30) hit = 1;
      else step();
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL reach_round_30: got round_cnt=%0d want 30", round_cnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_chain = 1'b0; model_cnt = 16'd0;
    n_checks++;
    if (round_cnt !== 6'd0 || rnd_en !== 1'b0 || blk_cnt !== 16'd0 ||
        blk_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_round: got rc=%0d rnd=%b cnt=%0d rdy=%b busy=%b want 0 0 0 1 0",
               round_cnt, rnd_en, blk_cnt, blk_ready, busy);
    end
    run_block(1'b0, 1'b1);   // chain was closed by reset: seq_err expected
    drain_out();
  endtask

  // ROUNDS=4 instance: round sequence, w_sel, and 7-cycle accept-to-accept.
  task automatic test_back_to_back_r4();
    int k = 0, n_rnd = 0;
    bit got = 0;
    logic [W-1:0] e;
    for (int r = 0; r < R4; r++) exp_q.push_back(W'(r));
    blk_valid_4 = 1'b1; blk_first_4 = 1'b1; blk_last_4 = 1'b0;
    step(); k++;
    blk_valid_4 = 1'b0; blk_first_4 = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      n_checks++;
      if (w_sel_4 !== 1'b0) begin
        n_fail++;
        $display("FAIL r4_w_sel_step_%0d: got %b want 0", k, w_sel_4);
      end
      if (rnd_en_4 === 1'b1) begin
        n_rnd++;
        if (exp_q.size() == 0) e = '1;
        else e = exp_q.pop_front();
        n_checks++;
        if (W'(round_cnt_4) !== e) begin
          n_fail++;
          $display("FAIL r4_round_cnt: got %0d want %0d", round_cnt_4, e);
        end
      end
      if (blk_ready_4 === 1'b1) got = 1;
      else begin step(); k++; end
    end
    n_checks++;
    if (k !== R4 + 3 || n_rnd !== R4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL r4_throughput: got gap=%0d rounds=%0d want gap=%0d rounds=%0d",
               k, n_rnd, R4 + 3, R4);
    end
    exp_q.delete();
    blk_valid_4 = 1'b1; blk_first_4 = 1'b0; blk_last_4 = 1'b1;
    step();
    blk_valid_4 = 1'b0; blk_last_4 = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (digest_valid_4 === 1'b1) got = 1;
      else step();
    end
    n_checks++;
    if (!got || blk_cnt_4 !== 16'd2 || seq_err_4 !== 1'b0) begin
      n_fail++;
      $display("FAIL r4_second_block: got dv=%b cnt=%0d want dv=1 cnt=2",
               digest_valid_4, blk_cnt_4);
    end
    digest_ready_4 = 1'b1;
    step();
    digest_ready_4 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0; digest_ready = 1'b0;
    blk_valid_4 = 1'b0; blk_first_4 = 1'b0; blk_last_4 = 1'b0;
    digest_ready_4 = 1'b0;
    model_chain = 1'b0; model_cnt = 16'd0;
    test_reset();
    test_single_block();
    test_two_block_stall();
    test_seq_err();
    test_reset_mid_round();
    test_back_to_back_r4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
